// File: rtl/fetch_unit.sv
// Sequential instruction fetch feeding decode through a small circular queue.
// At most one memory read is outstanding; a jump flushes everything and redirects fetch.
module fetch_unit #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter int unsigned      PC_STEP  = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   jump,
   input  logic [WIDTH-1:0]       jump_pc,
   output logic                   imem_req,
   output logic [WIDTH-1:0]       imem_addr,
   input  logic [WIDTH-1:0]       imem_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_instruction,
   output logic [WIDTH-1:0]       out_pc4,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned      PTR_W     = $clog2(DEPTH);
   localparam int unsigned      CNT_W     = PTR_W + 1;
   localparam logic [WIDTH-1:0] STEP      = WIDTH'(PC_STEP);
   localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             inflight_q, inflight_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [WIDTH-1:0] instr_mem [DEPTH];
   logic [WIDTH-1:0] pc4_mem   [DEPTH];

   logic has_room;
   logic push;
   logic pop;

   // Reserve a slot for the outstanding response so the queue can never overflow.
   assign has_room  = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_EXT;
   assign imem_req  = reset & ~jump & has_room;
   assign imem_addr = pc_q;

   assign out_valid       = (count_q != '0);
   assign out_instruction = instr_mem[rd_ptr_q];
   assign out_pc4         = pc4_mem[rd_ptr_q];
   assign count           = count_q;

   assign push = reset & ~jump & inflight_q;
   assign pop  = reset & ~jump & out_valid & out_ready;

   always_comb begin
      pc_d       = pc_q;
      inflight_d = imem_req;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (jump) begin
         pc_d       = jump_pc;
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (imem_req) pc_d = pc_q + STEP;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // While a response is in flight, pc_q already holds its issued address + PC_STEP.
   always_ff @(posedge clock) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_data;
         pc4_mem[wr_ptr_q]   <= pc_q;
      end
   end

endmodule
